// File: rtl/alu_uart_if.sv
// UART-byte sequencer for a combinational ALU: gathers A, B and opcode bytes, then streams the result back LSB first.
// Optional frame idle timeout is compiled in with `define ALU_IF_TIMEOUT_EN.
module alu_uart_if #(
    parameter int NB_DATA = 8,
    parameter int NB_REG  = 32,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 100000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic [NB_REG-1:0]  o_alu_a,
    output logic [NB_REG-1:0]  o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_REG-1:0]  i_alu_result,
    output logic               o_busy,
    output logic               o_timeout
);

    localparam int NBYTES = NB_REG / NB_DATA;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

    localparam logic [2:0] ST_RX_A  = 3'd0;
    localparam logic [2:0] ST_RX_B  = 3'd1;
    localparam logic [2:0] ST_RX_OP = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_TX    = 3'd4;

    if (((NB_REG % NB_DATA) != 0) || (NB_OP > NB_DATA) || (TIMEOUT < 1)) begin : g_param_check
        $error("alu_uart_if: illegal parameter combination");
    end

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_next;
    logic [NB_REG-1:0]  alu_a_q, alu_a_d;
    logic [NB_REG-1:0]  alu_b_q, alu_b_d;
    logic [NB_OP-1:0]   alu_op_q, alu_op_d;
    logic [NB_REG-1:0]  result_q, result_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;

`ifdef ALU_IF_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_q, timeout_d;
    logic              frame_active;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        result_d   = result_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        cnt_next   = cnt_q + CNT_W'(1);

        case (state_q)
            ST_RX_A: begin
                if (i_rx_done) begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            alu_a_d[k*NB_DATA +: NB_DATA] = i_rx_data;
                        end
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RX_B;
                    end else begin
                        cnt_d = cnt_next;
                    end
                end
            end
            ST_RX_B: begin
                if (i_rx_done) begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            alu_b_d[k*NB_DATA +: NB_DATA] = i_rx_data;
                        end
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RX_OP;
                    end else begin
                        cnt_d = cnt_next;
                    end
                end
            end
            ST_RX_OP: begin
                if (i_rx_done) begin
                    alu_op_d = i_rx_data[NB_OP-1:0];
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d   = i_alu_result;
                tx_data_d  = i_alu_result[NB_DATA-1:0];
                tx_start_d = 1'b1;
                cnt_d      = '0;
                state_d    = ST_TX;
            end
            ST_TX: begin
                // Received bytes are deliberately ignored here; only tx_done advances the stream.
                if (i_tx_done) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RX_A;
                    end else begin
                        cnt_d      = cnt_next;
                        tx_start_d = 1'b1;
                        for (int k = 0; k < NBYTES; k++) begin
                            if (cnt_next == CNT_W'(k)) begin
                                tx_data_d = result_q[k*NB_DATA +: NB_DATA];
                            end
                        end
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_RX_A;
            end
        endcase

`ifdef ALU_IF_TIMEOUT_EN
        // A frame is in progress once any byte of it has landed; an accepted byte wins over expiry.
        frame_active = (state_q == ST_RX_B) || (state_q == ST_RX_OP) ||
                       ((state_q == ST_RX_A) && (cnt_q != '0));
        idle_d    = idle_q;
        timeout_d = 1'b0;
        if (!frame_active || i_rx_done) begin
            idle_d = '0;
        end else if (idle_q == IDLE_LAST) begin
            idle_d    = '0;
            cnt_d     = '0;
            state_d   = ST_RX_A;
            timeout_d = 1'b1;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end
`endif

        busy_d = (state_d == ST_EXEC) || (state_d == ST_TX);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_RX_A;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            result_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            result_q   <= result_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

`ifdef ALU_IF_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_alu_uart_if.sv
// Directed bench for alu_uart_if: a bench-side ALU feeds the DUT, expected TX bytes flow through a scoreboard queue.
module tb_alu_uart_if;

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_done;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic [31:0] o_alu_a;
    logic [31:0] o_alu_b;
    logic [5:0]  o_alu_op;
    logic [31:0] i_alu_result;
    logic        o_busy;
    logic        o_timeout;

    int errors = 0;
    int checks = 0;
    logic [7:0] expQ[$];

    alu_uart_if #(
        .NB_DATA(8),
        .NB_REG (32),
        .NB_OP  (6),
        .TIMEOUT(50)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .i_tx_done   (i_tx_done),
        .o_alu_a     (o_alu_a),
        .o_alu_b     (o_alu_b),
        .o_alu_op    (o_alu_op),
        .i_alu_result(i_alu_result),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] aluModel(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
        case (op)
            6'h20:   aluModel = a + b;
            6'h22:   aluModel = a - b;
            6'h24:   aluModel = a & b;
            6'h25:   aluModel = a | b;
            6'h26:   aluModel = a ^ b;
            6'h27:   aluModel = ~(a | b);
            6'h03:   aluModel = $unsigned($signed(a) >>> b[4:0]);
            6'h02:   aluModel = a >> b[4:0];
            default: aluModel = 32'h0;
        endcase
    endfunction

    always_comb i_alu_result = aluModel(o_alu_a, o_alu_b, o_alu_op);

    // Hard stop so a wedged DUT can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_alu_a"},    o_alu_a, 32'h0);
        checkOutput({tag, "_alu_b"},    o_alu_b, 32'h0);
        checkOutput({tag, "_alu_op"},   {26'h0, o_alu_op}, 32'h0);
        checkOutput({tag, "_tx_data"},  {24'h0, o_tx_data}, 32'h0);
        checkOutput({tag, "_tx_start"}, {31'h0, o_tx_start}, 32'h0);
        checkOutput({tag, "_busy"},     {31'h0, o_busy}, 32'h0);
        checkOutput({tag, "_timeout"},  {31'h0, o_timeout}, 32'h0);
    endtask

    // Sends A from byte startByte, then B, then the OP byte; pushes the expected result bytes.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [7:0] opByte, input int startByte);
        logic [31:0] res;
        logic [5:0]  op;
        op  = opByte[5:0];
        res = aluModel(a, b, op);
        for (int k = 0; k < 4; k++) expQ.push_back(res[8*k +: 8]);
        for (int k = startByte; k < 4; k++) sendByte(a[8*k +: 8]);
        for (int k = 0; k < 4; k++) sendByte(b[8*k +: 8]);
        sendByte(opByte);
        checkOutput("alu_a", o_alu_a, a);
        checkOutput("alu_b", o_alu_b, b);
        checkOutput("alu_op", {26'h0, o_alu_op}, {26'h0, op});
        checkOutput("busy_exec", {31'h0, o_busy}, 32'h1);
        checkOutput("no_start_in_exec", {31'h0, o_tx_start}, 32'h0);
        tick();
        checkOutput("first_start_latency", {31'h0, o_tx_start}, 32'h1);
    endtask

    task automatic collectResult(input bit inject);
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            int waited = 0;
            while (!o_tx_start && waited < 50) begin
                tick();
                waited++;
            end
            checkOutput($sformatf("tx_start_seen%0d", i), {31'h0, o_tx_start}, 32'h1);
            checkOutput("scoreboard_nonempty", {31'h0, (expQ.size() > 0)}, 32'h1);
            exp = (expQ.size() > 0) ? expQ.pop_front() : 8'hxx;
            checkOutput($sformatf("tx_byte%0d", i), {24'h0, o_tx_data}, {24'h0, exp});
            tick();
            checkOutput("tx_start_one_cycle", {31'h0, o_tx_start}, 32'h0);
            if (inject) begin
                sendByte(8'hAA);
                checkOutput("busy_during_inject", {31'h0, o_busy}, 32'h1);
                checkOutput("no_start_on_rx", {31'h0, o_tx_start}, 32'h0);
            end
            tick();
            tick();
            checkOutput("tx_data_stable", {24'h0, o_tx_data}, {24'h0, exp});
            i_tx_done = 1'b1;
            if (inject && i == 1) begin
                i_rx_data = 8'hAA;
                i_rx_done = 1'b1;
            end
            tick();
            i_tx_done = 1'b0;
            i_rx_done = 1'b0;
            if (i == 3) checkOutput("idle_after_tx", {31'h0, o_busy}, 32'h0);
            else        checkOutput("next_start_after_done", {31'h0, o_tx_start}, 32'h1);
        end
    endtask

    initial begin
        int pulses;
        int firstPulse;
        i_rst     = 1'b1;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        tick();
        tick();
        checkAllZero("reset");
        i_rst = 1'b0;
        tick();

        $display("[TB] ADD with upper opcode bits set");
        applyStimulus(32'h0000_0005, 32'h0000_0003, 8'hE0, 0);
        collectResult(1'b0);

        $display("[TB] SUB underflow with RX bytes injected during TX");
        applyStimulus(32'h0000_0000, 32'h0000_0001, 8'h22, 0);
        collectResult(1'b1);

        $display("[TB] XOR frame right after injected bytes");
        applyStimulus(32'hDEAD_BEEF, 32'h0F0F_00FF, 8'h26, 0);
        collectResult(1'b0);

        $display("[TB] SRA of negative operand");
        applyStimulus(32'h8000_0000, 32'h0000_0004, 8'h03, 0);
        collectResult(1'b0);

        $display("[TB] async reset after three bytes of A");
        sendByte(8'h12);
        sendByte(8'h34);
        sendByte(8'h56);
        checkOutput("partial_a_before_reset", o_alu_a, 32'h8056_3412);
        i_rst = 1'b1;
        #2;
        checkAllZero("async_reset");
        tick();
        i_rst = 1'b0;
        tick();
        applyStimulus(32'h1234_5678, 32'h1111_1111, 8'h20, 0);
        collectResult(1'b0);

        $display("[TB] idle after two bytes of A");
        sendByte(8'h11);
        sendByte(8'h22);
        pulses     = 0;
        firstPulse = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (o_timeout) begin
                pulses++;
                if (firstPulse == 0) firstPulse = k;
            end
        end
`ifdef ALU_IF_TIMEOUT_EN
        checkOutput("timeout_pulse_cycle", firstPulse, 50);
        checkOutput("timeout_pulse_count", pulses, 1);
        applyStimulus(32'hCAFE_F00D, 32'h0000_0010, 8'h20, 0);
        collectResult(1'b0);
`else
        checkOutput("no_timeout_pulses", pulses, 0);
        applyStimulus(32'h4433_2211, 32'h0000_0001, 8'h20, 2);
        collectResult(1'b0);
`endif

        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
